ext_bus_target: RTL and testbench
=================================

EXT_BUS_TARGET -- requirements
Module: ext_bus_target

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address width of internal backing store (2^ADDR_W x 16 bits).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  16  multiplexed address/data bus, sampled.
- dout  out  16  read data toward bus pad.
- dout_en  out  1  pad drive enable, active high.
- ale0  in  1  low-address latch strobe, active high.
- ale1  in  1  high-address latch strobe, active high.
- oe_n  in  1  output enable, active low.
- we_n  in  1  write enable, active low.
- bhe_n  in  1  high byte enable, active low.
- bus_err  out  1  sticky protocol-error flag.

Function
REQ-003 SHALL pass ale0, ale1, oe_n, we_n, bhe_n and din through an identical input pipeline (see Configuration) so that controls and data stay cycle-aligned.
REQ-004 SHALL capture din into addr[15:0] on the detected falling edge of ale0, and into addr[31:16] on the detected falling edge of ale1.
REQ-005 SHALL use addr[0]=0 as low-byte enable, bhe_n=0 as high-byte enable, and addr[ADDR_W:1] as word index.
REQ-006 SHALL treat addr[31:ADDR_W+1] != 0 as out of range: reads return 16'h0000, writes are discarded.
REQ-007 SHALL implement states IDLE, READ, WRITE; reset state IDLE.
REQ-008 IDLE->READ on oe_n falling edge with we_n high; IDLE->WRITE on we_n falling edge; state entry snapshots addr and byte enables into cur_addr/cur_be.
REQ-009 SHALL, in READ, present the stored word on dout and assert dout_en exactly one cycle after READ entry, holding both until oe_n rising edge is detected.
REQ-010 SHALL deassert dout_en in the same cycle READ->IDLE is taken on oe_n rising edge.
REQ-011 SHALL, in WRITE, commit din to cur_addr on we_n rising edge, updating only the enabled bytes, then return to IDLE; dout_en stays 0 throughout WRITE.
REQ-012 SHALL, on oe_n and we_n both low in the same cycle, enter or stay in WRITE, keep dout_en 0, and set bus_err.
REQ-013 SHALL set bus_err on ale0/ale1 rising edge while in READ or WRITE; addr updates, cur_addr does not.
REQ-014 SHALL leave memory unchanged by reads, by writes with no byte enabled, and by a we_n pulse aborted by reset.
REQ-015 bus_err SHALL remain set until reset.

Reset
REQ-016 SHALL, while rst_n=0, force state IDLE, addr=0, cur_addr=0, cur_be=0, dout=16'h0000, dout_en=0, bus_err=0, pipeline flops to idle levels (oe_n, we_n, bhe_n=1; ale=0; din=0).
REQ-017 SHALL not reset backing-store contents.
REQ-018 SHALL abort any READ/WRITE in progress on reset with dout_en dropping asynchronously; first valid edge detection is the second clk edge after rst_n rises.

Configuration
REQ-019 With macro EXT_BUS_TARGET_SYNC_EN defined, the input pipeline SHALL be a two-flop synchronizer plus one edge-detect stage (3 cycles pin-to-edge-detect).
REQ-020 Without EXT_BUS_TARGET_SYNC_EN, the pipeline SHALL be a single register stage (1 cycle pin-to-edge-detect); all other timing relative to edge detection is unchanged.

Verification
REQ-021 ale0 pulse with din=16'h0010, ale1 pulse with din=0, we_n pulse with din=16'hBEEF, bhe_n=0 -> word 8 = 16'hBEEF, dout_en never 1.
REQ-022 Following read at same address (oe_n low 6 cycles) -> dout=16'hBEEF with dout_en=1 from one cycle after READ entry until oe_n rise detection, then 0.
REQ-023 Write at addr 16'h0011 (addr[0]=1), bhe_n=0, din=16'h12AA over 16'hBEEF -> word 8 = 16'h12EF.
REQ-024 ale1 with din=16'h0001 then read -> dout=16'h0000; prior write to that address leaves all in-range words unchanged.
REQ-025 oe_n and we_n driven low same cycle -> bus_err=1, dout_en=0, bus_err holds through 10 further idle cycles until rst_n=0.
REQ-026 rst_n pulsed low mid-READ -> dout_en=0 immediately, state IDLE; subsequent read of word 8 still returns 16'h12EF.

Source files
------------

// File: rtl/ext_bus_target.sv
// Multiplexed address/data bus target with a 2^ADDR_W x 16 backing store.
// Define EXT_BUS_TARGET_SYNC_EN to add a two-flop input synchronizer (3-cycle pin-to-edge-detect).
module ext_bus_target #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        dout_en,
  input  logic        ale0,
  input  logic        ale1,
  input  logic        oe_n,
  input  logic        we_n,
  input  logic        bhe_n,
  output logic        bus_err
);

  localparam int unsigned PW = 21;
  // Pipeline layout: {din, bhe_n, we_n, oe_n, ale1, ale0}
  localparam logic [PW-1:0] PipeIdle = {16'h0000, 3'b111, 2'b00};

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  logic [PW-1:0] pin_vec, stage_in, cur_q;
  logic [3:0]    ctl_prev_q;
  logic [15:0]   din_prev_q;

  assign pin_vec = {din, bhe_n, we_n, oe_n, ale1, ale0};

`ifdef EXT_BUS_TARGET_SYNC_EN
  logic [PW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= PipeIdle;
      sync2_q <= PipeIdle;
    end else begin
      sync1_q <= pin_vec;
      sync2_q <= sync1_q;
    end
  end

  assign stage_in = sync2_q;
`else
  assign stage_in = pin_vec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= PipeIdle;
      ctl_prev_q <= PipeIdle[3:0];
      din_prev_q <= 16'h0000;
    end else begin
      cur_q      <= stage_in;
      ctl_prev_q <= cur_q[3:0];
      din_prev_q <= cur_q[20:5];
    end
  end

  logic ale0_fall, ale1_fall, ale_rise, oe_fall, oe_rise, we_fall, we_rise, conflict;

  assign ale0_fall = ctl_prev_q[0] & ~cur_q[0];
  assign ale1_fall = ctl_prev_q[1] & ~cur_q[1];
  assign ale_rise  = (~ctl_prev_q[0] & cur_q[0]) | (~ctl_prev_q[1] & cur_q[1]);
  assign oe_fall   = ctl_prev_q[2] & ~cur_q[2];
  assign oe_rise   = ~ctl_prev_q[2] & cur_q[2];
  assign we_fall   = ctl_prev_q[3] & ~cur_q[3];
  assign we_rise   = ~ctl_prev_q[3] & cur_q[3];
  assign conflict  = ~cur_q[2] & ~cur_q[3];

  state_e      state_q, state_d;
  logic [31:0] addr_q, cur_addr_q;
  logic [1:0]  cur_be_q;
  logic [15:0] dout_q, dout_d;
  logic        dout_en_q, dout_en_d;
  logic        bus_err_q, bus_err_d;
  logic        rd_hold, wr_commit, snap, in_range;
  logic [15:0] rd_word;
  logic [ADDR_W-1:0] idx;
  logic [15:0] mem [2**ADDR_W];

  assign in_range = (cur_addr_q >> (ADDR_W + 1)) == 32'd0;
  assign idx      = cur_addr_q[ADDR_W:1];
  assign rd_word  = in_range ? mem[idx] : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cur_addr_q <= '0;
      cur_be_q   <= '0;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      bus_err_q <= bus_err_d;
      if (ale0_fall) addr_q[15:0]  <= din_prev_q;
      if (ale1_fall) addr_q[31:16] <= din_prev_q;
      if (snap) begin
        cur_addr_q <= addr_q;
        cur_be_q   <= {~cur_q[4], ~addr_q[0]};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (conflict || we_fall) state_d = StWrite;
        else if (oe_fall)        state_d = StRead;
      end
      StRead: begin
        if (conflict)     state_d = StWrite;
        else if (oe_rise) state_d = StIdle;
      end
      StWrite: begin
        if (we_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_hold   = (state_q == StRead) && (state_d == StRead);
    dout_en_d = rd_hold;
    dout_d    = rd_hold ? rd_word : 16'h0000;
    bus_err_d = bus_err_q | conflict | (ale_rise && (state_q != StIdle));
    wr_commit = (state_q == StWrite) && we_rise && in_range;
    snap      = (state_d != state_q) && (state_d != StIdle);
  end

  // Backing store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      if (cur_be_q[0]) mem[idx][7:0]  <= din_prev_q[7:0];
      if (cur_be_q[1]) mem[idx][15:8] <= din_prev_q[15:8];
    end
  end

  assign dout    = dout_q;
  assign dout_en = dout_en_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_ext_bus_target.sv
// Randomized bench for ext_bus_target, checked every cycle against a transaction-level model.
module tb_ext_bus_target;

`ifdef EXT_BUS_TARGET_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif
  localparam int BIG = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0, dout;
  logic        dout_en, bus_err;
  logic        ale0 = 1'b0, ale1 = 1'b0, oe_n = 1'b1, we_n = 1'b1, bhe_n = 1'b1;

  ext_bus_target #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .dout_en(dout_en),
    .ale0(ale0), .ale1(ale1), .oe_n(oe_n), .we_n(we_n), .bhe_n(bhe_n), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  logic [15:0] mem_m [256];
  logic [31:0] addr_m = '0;
  bit          rd_act = 0, err_set = 0, chk_on = 0;
  int          rd_fall = 0, rd_rise = BIG, err_cyc = 0, en_cnt = 0;
  logic [15:0] rd_exp = '0, last_rd = '0;
  logic        exp_en, exp_err;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> 9) == 32'd0;
  endfunction

  function automatic logic [15:0] model_rd();
    return in_rng(addr_m) ? mem_m[addr_m[8:1]] : 16'h0000;
  endfunction

  task automatic model_wr(input logic [15:0] d, input logic bhe);
    if (in_rng(addr_m)) begin
      if (!addr_m[0]) mem_m[addr_m[8:1]][7:0]  = d[7:0];
      if (!bhe)       mem_m[addr_m[8:1]][15:8] = d[15:8];
    end
  endtask

  // Read data window: opens L+2 cycles after oe_n falls, closes L+1 cycles after it rises.
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      exp_en  = rd_act && (cyc >= rd_fall + L + 2) && (cyc < rd_rise + L + 1);
      exp_err = err_set && (cyc >= err_cyc + L + 1);
      chk("dout_en", {15'h0, dout_en}, {15'h0, exp_en});
      chk("bus_err", {15'h0, bus_err}, {15'h0, exp_err});
      if (exp_en) chk("dout", dout, rd_exp);
      if (dout_en) begin
        en_cnt++;
        last_rd = dout;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ale(input bit hi, input logic [15:0] a);
    din = a;
    step(1);
    if (hi) ale1 = 1'b1;
    else    ale0 = 1'b1;
    step(2);
    ale0 = 1'b0;
    ale1 = 1'b0;
    step(3);
    if (hi) addr_m[31:16] = a;
    else    addr_m[15:0]  = a;
  endtask

  task automatic do_write(input logic [15:0] d, input logic bhe);
    en_cnt = 0;
    din    = d;
    bhe_n  = bhe;
    we_n   = 1'b0;
    step(3);
    we_n = 1'b1;
    model_wr(d, bhe);
    step(L + 3);
    bhe_n = 1'b1;
  endtask

  task automatic do_read(input int n);
    rd_exp  = model_rd();
    en_cnt  = 0;
    last_rd = 'x;
    rd_fall = cyc;
    rd_rise = BIG;
    rd_act  = 1;
    oe_n    = 1'b0;
    step(n);
    oe_n    = 1'b1;
    rd_rise = cyc;
    step(L + 3);
    rd_act = 0;
  endtask

  task automatic do_reset();
    ale0 = 1'b0; ale1 = 1'b0; oe_n = 1'b1; we_n = 1'b1; bhe_n = 1'b1; din = '0;
    rst_n   = 1'b0;
    rd_act  = 0;
    err_set = 0;
    addr_m  = '0;
    step(2);
    rst_n = 1'b1;
    step(L + 2);
  endtask

  initial begin
    int unsigned w;
    step(2);
    chk("rst_dout_en", {15'h0, dout_en}, 16'h0000);
    chk("rst_bus_err", {15'h0, bus_err}, 16'h0000);
    chk("rst_dout", dout, 16'h0000);
    do_reset();
    chk_on = 1;

    for (int i = 0; i < 256; i++) begin
      do_ale(1'b0, 16'(i * 2));
      do_write(16'($urandom), 1'b0);
    end

    do_ale(1'b0, 16'h0010);
    do_ale(1'b1, 16'h0000);
    do_write(16'hBEEF, 1'b0);
    chk("wr_no_dout_en", 16'(en_cnt), 16'd0);
    do_read(6);
    chk("rd_beef", last_rd, 16'hBEEF);
    chk("rd_en_cycles", 16'(en_cnt), 16'd5);

    do_ale(1'b0, 16'h0011);
    do_write(16'h12AA, 1'b0);
    do_read(3);
    chk("rd_hi_byte_only", last_rd, 16'h12EF);

    do_ale(1'b1, 16'h0001);
    do_write(16'h7777, 1'b0);
    do_read(4);
    chk("rd_out_of_range", last_rd, 16'h0000);
    do_ale(1'b1, 16'h0000);
    do_read(4);
    chk("oor_wr_dropped", last_rd, 16'h12EF);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 7) == 0) do_ale(1'b1, 16'($urandom_range(1, 65535)));
      else if (addr_m[31:16] != 16'h0) do_ale(1'b1, 16'h0000);
      w = $urandom_range(0, 254);
      if (w >= 8) w++;
      do_ale(1'b0, {7'h00, w[7:0], 1'($urandom_range(0, 1))});
      if ($urandom_range(0, 1) == 1) do_write(16'($urandom), 1'($urandom_range(0, 1)));
      else do_read(int'($urandom_range(2, 6)));
    end

    // Conflict at an out-of-range address so the implied write leaves the store alone.
    do_ale(1'b1, 16'h0001);
    din     = 16'h5555;
    oe_n    = 1'b0;
    we_n    = 1'b0;
    err_set = 1;
    err_cyc = cyc;
    step(3);
    oe_n = 1'b1;
    we_n = 1'b1;
    model_wr(16'h5555, bhe_n);
    step(L + 3);
    step(10);
    chk("err_sticky", {15'h0, bus_err}, 16'h0001);
    chk("conflict_no_en", {15'h0, dout_en}, 16'h0000);
    do_reset();
    chk("err_cleared", {15'h0, bus_err}, 16'h0000);

    do_ale(1'b0, 16'h0010);
    rd_exp  = model_rd();
    rd_fall = cyc;
    rd_rise = BIG;
    rd_act  = 1;
    oe_n    = 1'b0;
    step(L + 4);
    chk("pre_rst_en", {15'h0, dout_en}, 16'h0001);
    rst_n   = 1'b0;
    oe_n    = 1'b1;
    rd_act  = 0;
    err_set = 0;
    addr_m  = '0;
    #1;
    chk("rst_async_en", {15'h0, dout_en}, 16'h0000);
    step(2);
    rst_n = 1'b1;
    step(L + 2);
    do_ale(1'b0, 16'h0010);
    do_read(4);
    chk("word8_after_rst", last_rd, 16'h12EF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
